// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter
// Round-robin arbiter for the single write port of the 32x64 FP register
// file. N_REQ producers (adder, multiplier, divider, FP load) offer results
// through a valid/ready handshake. The winner's result is registered and
// drives regWr/rW/busW one cycle later. Writes to r0 are consumed but never
// enabled. A saturating counter records cycles with two or more pending
// requests.
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous active-low reset
//   wb_stall        write port reserved this cycle: no grant
//   req_valid       per-requester result pending
//   req_rd          destination indices, slice i = [i*ADDR_W +: ADDR_W]
//   req_data        result data,         slice i = [i*DATA_W +: DATA_W]
//   req_ready       one-hot combinational grant
//   regWr/rW/busW   registered register-file write port
//   contention_cnt  saturating count of cycles with >= 2 valid requests
module fp_wb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_stall,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_rd,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      regWr,
  output logic [ADDR_W-1:0]         rW,
  output logic [DATA_W-1:0]         busW,
  output logic [CNT_W-1:0]          contention_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              contended;

  // Search from rr_ptr upward with wrap; the first valid requester wins.
  // Only req_valid, wb_stall and rr_ptr feed the grant.
  always_comb begin
    int idx;
    idx       = 0;
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (!wb_stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!grant_any && req_valid[idx]) begin
          grant_any      = 1'b1;
          req_ready[idx] = 1'b1;
          grant_idx      = PTR_W'(idx);
        end
      end
    end
  end

  assign sel_rd   = req_rd[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

  // Explicit wrap so non-power-of-two N_REQ still cycles correctly.
  assign next_ptr = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;

  assign contended = ($countones(req_valid) >= 2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWr          <= 1'b0;
      rW             <= '0;
      busW           <= '0;
      rr_ptr         <= '0;
      contention_cnt <= '0;
    end else begin
      // A grant always implies a transfer because grants only land on valid bits.
      // rd=0 is consumed and recorded on rW/busW, but the write is suppressed.
      regWr <= grant_any && (sel_rd != '0);
      if (grant_any) begin
        rW     <= sel_rd;
        busW   <= sel_data;
        rr_ptr <= next_ptr;
      end
      if (contended && (contention_cnt != '1))
        contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Bench for fp_wb_arbiter: table of grant vectors plus hand sequences for
// counter saturation (second instance with CNT_W=4) and reset mid-write.
module tb_fp_wb_arbiter;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         wb_stall;
  logic [3:0]   req_valid;
  logic [19:0]  req_rd;
  logic [255:0] req_data;

  logic [3:0]   req_ready;
  logic         regWr;
  logic [4:0]   rW;
  logic [63:0]  busW;
  logic [15:0]  contention_cnt;

  logic [3:0]   ready4;
  logic         regWr4;
  logic [4:0]   rW4;
  logic [63:0]  busW4;
  logic [3:0]   cnt4;

  fp_wb_arbiter dut (
    .clk(clk), .reset(reset), .wb_stall(wb_stall), .req_valid(req_valid),
    .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .regWr(regWr), .rW(rW), .busW(busW), .contention_cnt(contention_cnt)
  );

  fp_wb_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .wb_stall(wb_stall), .req_valid(req_valid),
    .req_rd(req_rd), .req_data(req_data), .req_ready(ready4),
    .regWr(regWr4), .rW(rW4), .busW(busW4), .contention_cnt(cnt4)
  );

  typedef struct {
    logic       wr;
    logic [4:0] rd;
    logic [63:0] d;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    bit          rst;
    logic [3:0]  valid;
    logic        stall;
    logic [19:0] rd;
    logic [63:0] dat;
    logic [3:0]  exp;
  } vec_t;
  vec_t tv[18];

  int total = 0;
  int bad   = 0;

  logic [1:0]  m_ptr;
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt4;
  logic [4:0]  m_rW;
  logic [63:0] m_busW;

  localparam logic [63:0] PI_D = 64'h4009_21FB_5444_2D18;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_grant(input logic [1:0] ptr, input logic [3:0] v,
                                             input logic st);
    logic [3:0] r;
    int j;
    r = 4'b0;
    if (st) return r;
    j = int'(ptr);
    repeat (4) begin
      if (v[j] && r == 4'b0) r[j] = 1'b1;
      j = (j + 1) % 4;
    end
    return r;
  endfunction

  task automatic set_data(input logic [63:0] dat);
    for (int i = 0; i < 4; i++)
      req_data[i*64 +: 64] = dat ^ (64'(i) << 60);
  endtask

  task automatic model_reset();
    m_ptr  = '0;
    m_cnt  = '0;
    m_cnt4 = '0;
    m_rW   = '0;
    m_busW = '0;
    sb.delete();
  endtask

  // Inputs are set by the caller shortly after a rising edge.
  task automatic step(input bit use_exp, input logic [3:0] exp);
    logic [3:0] g;
    int gi;
    wr_t e;
    @(negedge clk);
    g = model_grant(m_ptr, req_valid, wb_stall);
    if (use_exp) chk("tbl_grant", 64'(req_ready), 64'(exp));
    chk("mdl_grant", 64'(req_ready), 64'(g));
    gi = -1;
    for (int i = 0; i < 4; i++) if (g[i]) gi = i;
    e.wr = 1'b0;
    if (gi >= 0) begin
      m_rW   = req_rd[gi*5 +: 5];
      m_busW = req_data[gi*64 +: 64];
      e.wr   = (m_rW != 5'd0);
      m_ptr  = 2'((gi + 1) % 4);
    end
    e.rd = m_rW;
    e.d  = m_busW;
    sb.push_back(e);
    if ($countones(req_valid) >= 2) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_cnt4 != 4'hF)    m_cnt4 = m_cnt4 + 4'd1;
    end
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      chk("regWr", 64'(regWr), 64'(e.wr));
      chk("rW", 64'(rW), 64'(e.rd));
      chk("busW", busW, e.d);
    end
    chk("cnt", 64'(contention_cnt), 64'(m_cnt));
    chk("cnt4", 64'(cnt4), 64'(m_cnt4));
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    wb_stall  = 1'b0;
    #1;
    chk("rst_regWr", 64'(regWr), 64'(0));
    chk("rst_rW", 64'(rW), 64'(0));
    chk("rst_busW", busW, 64'(0));
    chk("rst_cnt", 64'(contention_cnt), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset     = 1'b0;
    wb_stall  = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    model_reset();

    //        rst   valid    stall rd {3,2,1,0}                   data                    exp
    tv[0]  = '{1'b1, 4'b0001, 1'b0, {5'd0, 5'd0, 5'd0, 5'd3},    PI_D,                   4'b0001};
    tv[1]  = '{1'b0, 4'b0000, 1'b0, {5'd0, 5'd0, 5'd0, 5'd3},    PI_D,                   4'b0000};
    tv[2]  = '{1'b1, 4'b1111, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1},    64'h0123_4567_89AB_CDEF, 4'b0001};
    tv[3]  = '{1'b0, 4'b1111, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1},    64'h0123_4567_89AB_CDEF, 4'b0010};
    tv[4]  = '{1'b0, 4'b1111, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1},    64'h0123_4567_89AB_CDEF, 4'b0100};
    tv[5]  = '{1'b0, 4'b1111, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1},    64'h0123_4567_89AB_CDEF, 4'b1000};
    tv[6]  = '{1'b0, 4'b1111, 1'b0, {5'd8, 5'd7, 5'd6, 5'd5},    64'h0FED_CBA9_8765_4321, 4'b0001};
    tv[7]  = '{1'b0, 4'b1111, 1'b0, {5'd8, 5'd7, 5'd6, 5'd5},    64'h0FED_CBA9_8765_4321, 4'b0010};
    tv[8]  = '{1'b0, 4'b1111, 1'b0, {5'd8, 5'd7, 5'd6, 5'd5},    64'h0FED_CBA9_8765_4321, 4'b0100};
    tv[9]  = '{1'b0, 4'b1111, 1'b0, {5'd8, 5'd7, 5'd6, 5'd5},    64'h0FED_CBA9_8765_4321, 4'b1000};
    tv[10] = '{1'b0, 4'b0100, 1'b0, {5'd9, 5'd0, 5'd0, 5'd0},    64'hDFFF_FFFF_FFFF_FFFF, 4'b0100};
    tv[11] = '{1'b0, 4'b1100, 1'b0, {5'd9, 5'd0, 5'd0, 5'd0},    64'h0000_1111_2222_3333, 4'b1000};
    tv[12] = '{1'b0, 4'b0000, 1'b0, {5'd9, 5'd0, 5'd0, 5'd0},    64'h0000_1111_2222_3333, 4'b0000};
    tv[13] = '{1'b1, 4'b0110, 1'b1, {5'd0, 5'd6, 5'd5, 5'd0},    64'h5555_AAAA_5555_AAAA, 4'b0000};
    tv[14] = '{1'b0, 4'b0110, 1'b1, {5'd0, 5'd6, 5'd5, 5'd0},    64'h5555_AAAA_5555_AAAA, 4'b0000};
    tv[15] = '{1'b0, 4'b0110, 1'b1, {5'd0, 5'd6, 5'd5, 5'd0},    64'h5555_AAAA_5555_AAAA, 4'b0000};
    tv[16] = '{1'b0, 4'b0110, 1'b0, {5'd0, 5'd6, 5'd5, 5'd0},    64'h5555_AAAA_5555_AAAA, 4'b0010};
    tv[17] = '{1'b0, 4'b0000, 1'b0, {5'd0, 5'd6, 5'd5, 5'd0},    64'h5555_AAAA_5555_AAAA, 4'b0000};

    for (int n = 0; n < 18; n++) begin
      if (tv[n].rst) do_reset();
      req_valid = tv[n].valid;
      wb_stall  = tv[n].stall;
      req_rd    = tv[n].rd;
      set_data(tv[n].dat);
      step(1'b1, tv[n].exp);
      if (n == 0) begin
        chk("t1_regWr", 64'(regWr), 64'(1));
        chk("t1_rW", 64'(rW), 64'(3));
        chk("t1_busW", busW, PI_D);
      end
      if (n == 9)  chk("t2_cnt8", 64'(contention_cnt), 64'(8));
      if (n == 10) begin
        chk("t3_r0_regWr", 64'(regWr), 64'(0));
        chk("t3_r0_rW", 64'(rW), 64'(0));
      end
      if (n == 15) chk("t4_cnt3", 64'(contention_cnt), 64'(3));
    end

    // Saturation of the narrow counter.
    do_reset();
    req_valid = 4'b0011;
    req_rd    = {5'd0, 5'd0, 5'd12, 5'd11};
    set_data(64'h3FF0_0000_0000_0000);
    repeat (20) step(1'b0, 4'b0000);
    chk("cnt4_sat", 64'(cnt4), 64'(15));
    chk("cnt16_20", 64'(contention_cnt), 64'(20));
    req_valid = 4'b0000;
    step(1'b0, 4'b0000);
    chk("cnt4_hold", 64'(cnt4), 64'(15));

    // Reset while a write to r7 is sitting in the output register.
    do_reset();
    req_valid = 4'b0010;
    req_rd    = {5'd0, 5'd0, 5'd7, 5'd0};
    set_data(64'hC000_0000_0000_0001);
    step(1'b1, 4'b0010);
    req_valid = 4'b0000;
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_regWr", 64'(regWr), 64'(0));
    chk("midrst_rW", 64'(rW), 64'(0));
    chk("midrst_busW", busW, 64'(0));
    @(posedge clk);
    #1;
    chk("midrst_hold", 64'(regWr), 64'(0));
    reset = 1'b1;
    model_reset();
    req_valid = 4'b1010;
    req_rd    = {5'd8, 5'd0, 5'd7, 5'd0};
    step(1'b1, 4'b0010);
    req_valid = 4'b0000;
    step(1'b1, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
